// File: rtl/axi_fsrc_sequencer_core_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_fsrc_sequencer_core_if
// Description : Control/status bundle for the frame-source GPIO/trigger
//               sequencer. The master modport drives configuration and start
//               controls; the slave modport is the sequencer core side.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_fsrc_sequencer_core_if #(
    parameter int CTRL_WIDTH    = 40,
    parameter int COUNTER_WIDTH = 4,
    parameter int NUM_TRIG      = 4
);
    logic [31:0]                       seq_gpio_change_cnt;
    logic                              seq_start;
    logic                              seq_en;
    logic                              seq_ext_trig_en;
    logic                              ext_trig;
    logic [CTRL_WIDTH-1:0]             dut_seq_gpio_w;
    logic [NUM_TRIG-1:0]               trig_mask;
    logic [NUM_TRIG*COUNTER_WIDTH-1:0] first_trig_cnt;
    logic [CTRL_WIDTH-1:0]             dut_gpio;
    logic [NUM_TRIG-1:0]               trig_out;
    logic                              seq_busy;
    logic [1:0]                        seq_state;

    modport master (
        output seq_gpio_change_cnt, seq_start, seq_en, seq_ext_trig_en,
               ext_trig, dut_seq_gpio_w, trig_mask, first_trig_cnt,
        input  dut_gpio, trig_out, seq_busy, seq_state
    );

    modport slave (
        input  seq_gpio_change_cnt, seq_start, seq_en, seq_ext_trig_en,
               ext_trig, dut_seq_gpio_w, trig_mask, first_trig_cnt,
        output dut_gpio, trig_out, seq_busy, seq_state
    );
endinterface
`default_nettype wire

// File: rtl/axi_fsrc_sequencer_core.sv
`default_nettype none
// ============================================================================
// Module      : axi_fsrc_sequencer_core
// Description : Period-based GPIO/trigger sequencer. A start edge launches a
//               run of fixed-length periods; even periods drive the GPIO
//               pattern, odd periods drive zero, and each masked trigger
//               pulses once when the period index reaches its compare value.
//               Optional feature macro: FSRC_SEQ_EXT_TRIG_EN (adds the ARMED
//               state that waits for an ext_trig rising edge).
// Revision    : 1.0 - initial release
// ============================================================================
module axi_fsrc_sequencer_core #(
    parameter int CTRL_WIDTH    = 40,
    parameter int COUNTER_WIDTH = 4,
    parameter int NUM_TRIG      = 4
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    axi_fsrc_sequencer_core_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                   r_state;
    logic                     r_start_d;
    logic [31:0]              r_len;
    logic [31:0]              r_cnt;
    logic [COUNTER_WIDTH-1:0] r_pidx;
    logic [NUM_TRIG-1:0]      r_fired;
    logic [NUM_TRIG-1:0]      r_trig;
    logic [CTRL_WIDTH-1:0]    r_gpio;

    logic                     w_start_edge;
    logic                     w_ext_edge;
    logic                     w_use_ext;
    logic                     w_enter_run;
    logic                     w_arm;
    logic                     w_boundary;
    logic [31:0]              w_len_in;
    logic [COUNTER_WIDTH-1:0] w_pidx_next;
    logic [NUM_TRIG-1:0]      w_hit_first;
    logic [NUM_TRIG-1:0]      w_hit_next;

    assign w_start_edge = bus.seq_start & ~r_start_d;

`ifdef FSRC_SEQ_EXT_TRIG_EN
    logic r_ext_d;

    // ext_trig history for rising-edge detection while ARMED
    always_ff @(posedge clk) begin
        if (!resetn) r_ext_d <= 1'b0;
        else         r_ext_d <= bus.ext_trig;
    end

    assign w_ext_edge = bus.ext_trig & ~r_ext_d;
    assign w_use_ext  = bus.seq_ext_trig_en;
`else
    // External trigger path is absent in this build; inputs are left dangling.
    wire w_unused_ext = &{1'b0, bus.ext_trig, bus.seq_ext_trig_en};
    assign w_ext_edge = 1'b0;
    assign w_use_ext  = 1'b0;
`endif

    assign w_enter_run = ((r_state == ST_IDLE) && w_start_edge && !w_use_ext) ||
                         ((r_state == ST_ARMED) && w_ext_edge);
    assign w_arm       = (r_state == ST_IDLE) && w_start_edge && w_use_ext;

    // A zero period length would never complete a period; treat it as one cycle.
    assign w_len_in    = (bus.seq_gpio_change_cnt == 32'd0) ? 32'd1 : bus.seq_gpio_change_cnt;
    assign w_boundary  = (r_cnt == (r_len - 32'd1));
    assign w_pidx_next = (&r_pidx) ? r_pidx : (r_pidx + COUNTER_WIDTH'(1));

    // Per-trigger compare against period 0 (run entry) and the upcoming period
    always_comb begin
        w_hit_first = '0;
        w_hit_next  = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            w_hit_first[i] = (bus.first_trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH] == '0);
            w_hit_next[i]  = (bus.first_trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH] == w_pidx_next);
        end
    end

    // Sequencer FSM: outputs are computed for the cycle being entered so that
    // GPIO and trigger changes line up with the first cycle of each period.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_start_d <= 1'b0;
            r_len     <= 32'd0;
            r_cnt     <= 32'd0;
            r_pidx    <= '0;
            r_fired   <= '0;
            r_trig    <= '0;
            r_gpio    <= '0;
        end else begin
            r_start_d <= bus.seq_start;
            r_trig    <= '0;
            if (!bus.seq_en) begin
                r_state <= ST_IDLE;
                r_gpio  <= '0;
                r_cnt   <= 32'd0;
                r_pidx  <= '0;
                r_fired <= '0;
            end else if (w_enter_run) begin
                r_state <= ST_RUN;
                r_len   <= w_len_in;
                r_cnt   <= 32'd0;
                r_pidx  <= '0;
                r_gpio  <= bus.dut_seq_gpio_w;
                r_trig  <= bus.trig_mask & w_hit_first;
                r_fired <= bus.trig_mask & w_hit_first;
            end else if (w_arm) begin
                r_state <= ST_ARMED;
            end else if (r_state == ST_RUN) begin
                if (w_boundary) begin
                    r_cnt   <= 32'd0;
                    r_pidx  <= w_pidx_next;
                    r_gpio  <= w_pidx_next[0] ? '0 : bus.dut_seq_gpio_w;
                    r_trig  <= bus.trig_mask & w_hit_next & ~r_fired;
                    r_fired <= r_fired | (bus.trig_mask & w_hit_next);
                end else begin
                    r_cnt   <= r_cnt + 32'd1;
                end
            end
        end
    end

    assign bus.dut_gpio  = r_gpio;
    assign bus.trig_out  = r_trig;
    assign bus.seq_busy  = (r_state != ST_IDLE);
    assign bus.seq_state = r_state;

endmodule
`default_nettype wire

// File: doc/axi_fsrc_sequencer_core.md
AXI_FSRC_SEQUENCER_CORE -- requirements
Module: axi_fsrc_sequencer_core

Interface
REQ-001 SHALL have parameter CTRL_WIDTH, default 40, width of GPIO control word.
REQ-002 SHALL have parameter COUNTER_WIDTH, default 4, width of period-index and per-trigger compare values.
REQ-003 SHALL have parameter NUM_TRIG, default 4, number of trigger outputs.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-006 SHALL have port seq_gpio_change_cnt  input  32  period length in clk cycles.
REQ-007 SHALL have port seq_start  input  1  start level; rising edge starts a run.
REQ-008 SHALL have port seq_en  input  1  sequencer enable; low forces IDLE.
REQ-009 SHALL have port seq_ext_trig_en  input  1  wait for ext_trig before running.
REQ-010 SHALL have port ext_trig  input  1  external trigger, synchronous to clk.
REQ-011 SHALL have port dut_seq_gpio_w  input  CTRL_WIDTH  GPIO pattern for active periods.
REQ-012 SHALL have port trig_mask  input  NUM_TRIG  per-trigger enable.
REQ-013 SHALL have port first_trig_cnt  input  NUM_TRIG x COUNTER_WIDTH  period index at which each trigger fires.
REQ-014 SHALL have port dut_gpio  output  CTRL_WIDTH  registered GPIO drive.
REQ-015 SHALL have port trig_out  output  NUM_TRIG  registered one-cycle trigger pulses.
REQ-016 SHALL have port seq_busy  output  1  high when state is not IDLE.
REQ-017 SHALL have port seq_state  output  2  IDLE=0, ARMED=1, RUN=2.

Function
REQ-018 SHALL implement FSM IDLE, ARMED, RUN; start_edge = seq_start high this cycle and low the previous cycle.
REQ-019 IDLE: start_edge with seq_en=1 SHALL go to ARMED if seq_ext_trig_en=1, else to RUN, on the next clk.
REQ-020 ARMED: rising edge of ext_trig SHALL go to RUN on the next clk; other inputs SHALL hold ARMED.
REQ-021 seq_en=0 in any state SHALL force IDLE next clk with dut_gpio=0 and trig_out=0; seq_en dominates a simultaneous start_edge.
REQ-022 start_edge in ARMED or RUN SHALL be ignored.
REQ-023 On RUN entry SHALL latch seq_gpio_change_cnt as period length L; value 0 SHALL be treated as 1; later changes SHALL not affect the run.
REQ-024 RUN SHALL count cycles 0..L-1 per period; the first cycle of period 0 is the first RUN cycle (start_edge at cycle N gives RUN at N+1 without ext trig).
REQ-025 Period index pidx (COUNTER_WIDTH bits) SHALL start at 0 and increment at each period boundary, saturating at all-ones.
REQ-026 dut_gpio SHALL equal dut_seq_gpio_w sampled on the first cycle of even periods and 0 on odd periods, held for the period.
REQ-027 trig_out[i] SHALL pulse for exactly one cycle on the first cycle of the period where pidx == first_trig_cnt[i], only if trig_mask[i]=1, once per run (fired flag cleared on RUN entry).
REQ-028 With pidx saturated, pulses SHALL not repeat; first_trig_cnt[i]=all-ones SHALL fire once when pidx first reaches all-ones.
REQ-029 RUN SHALL continue until seq_en=0; 32-bit cycle counter SHALL never overflow past L-1.

Reset
REQ-030 resetn=0 at a rising clk edge SHALL set state IDLE, dut_gpio=0, trig_out=0, seq_busy=0, seq_state=0, all counters, fired flags and the start-edge history to 0.
REQ-031 Reset mid-run SHALL abort immediately; a seq_start already high when resetn deasserts SHALL register as a start_edge on the first cycle after reset.

Configuration
REQ-032 Macro FSRC_SEQ_EXT_TRIG_EN defined: ARMED state and ext_trig path SHALL be implemented per REQ-019/020.
REQ-033 Macro FSRC_SEQ_EXT_TRIG_EN undefined: ports SHALL remain, seq_ext_trig_en and ext_trig SHALL be ignored, IDLE SHALL go directly to RUN, seq_state SHALL never read 1.

Verification
REQ-034 L=4, mask=4'b0001, first_trig_cnt[0]=2, gpio_w=40'hA5, start edge at cycle 10 -> RUN at 11; dut_gpio=A5 cycles 11-14, 0 cycles 15-18, A5 from 19; trig_out[0] high only at cycle 19.
REQ-035 L=0 -> period of 1 cycle; dut_gpio toggles A5/0 every cycle; first_trig_cnt[1]=3 with mask bit 1 -> single pulse at 4th RUN cycle.
REQ-036 ext_trig_en=1 (macro defined) -> seq_state=1 until ext_trig rising edge, RUN next clk; macro undefined -> RUN directly, ext_trig ignored.
REQ-037 seq_en dropped mid-period and start_edge concurrent with seq_en=0 -> IDLE next clk, dut_gpio=0, no trigger; second start while RUN ignored.
REQ-038 COUNTER_WIDTH=4, first_trig_cnt=15, L=2 -> one pulse at period 15, none afterwards over 40 further periods; resetn low mid-run -> all outputs 0 next clk.
